mem_sram_resp: RTL and testbench

//  Responder (slave) end of the data-memory valid/ready bus that the MEM stage drives after its CLINT distributor.

---
 rtl/mem_sram_resp_pkg.sv | 43 ++++
 rtl/mem_sram_resp_lane.sv | 29 ++
 rtl/mem_sram_resp.sv | 132 +++++++++++++
 tb/tb_mem_sram_resp.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_resp_pkg.sv
// Shared types and constants for the mem-side SRAM responder: bus widths,
// transfer size and response codes, FSM states and the byte-mask helper.
package mem_sram_resp_pkg;

    localparam int DATA_BUS      = 64;
    localparam int DATA_ADDR_BUS = 64;

    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Unshifted byte mask covering the N bytes of a transfer of the given size.
    function automatic logic [7:0] size_mask(input size_e size);
        logic [7:0] mask;
        mask = 8'h01;
        case (size)
            SIZE_B: mask = 8'h01;
            SIZE_H: mask = 8'h03;
            SIZE_W: mask = 8'h0F;
            SIZE_D: mask = 8'hFF;
            default: mask = 8'h01;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_sram_resp_lane.sv
// Byte-lane steering for one request: strobe, lane-aligned write data and
// the natural-alignment check, all derived from size and addr[2:0].
module mem_sram_resp_lane
    import mem_sram_resp_pkg::*;
(
    input  logic [1:0]          size,
    input  logic [2:0]          offset,
    input  logic [DATA_BUS-1:0] wdata,
    output logic [7:0]          strobe,
    output logic [DATA_BUS-1:0] wdata_shifted,
    output logic                misaligned
);

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        misaligned = 1'b0;
        case (size_e'(size))
            SIZE_B: misaligned = 1'b0;
            SIZE_H: misaligned = offset[0];
            SIZE_W: misaligned = |offset[1:0];
            SIZE_D: misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
    end

    assign strobe        = size_mask(size_e'(size)) << offset;
    assign wdata_shifted = wdata << {offset, 3'b000};

endmodule

// File: rtl/mem_sram_resp.sv
// Data-memory responder: accepts one valid/ready request at a time, waits a
// fixed latency, then performs a byte-lane write or a doubleword read.
module mem_sram_resp
    import mem_sram_resp_pkg::*;
#(
    parameter logic [DATA_ADDR_BUS-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
    parameter int unsigned              DEPTH_LOG2 = 16,
    parameter int unsigned              LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_sram_resp_valid_i,
    input  logic                     mem_sram_resp_req_i,
    input  logic [DATA_ADDR_BUS-1:0] mem_sram_resp_addr_i,
    input  logic [1:0]               mem_sram_resp_size_i,
    input  logic [DATA_BUS-1:0]      mem_sram_resp_data_write_i,
    output logic                     mem_sram_resp_ready_o,
    output logic [DATA_BUS-1:0]      mem_sram_resp_data_read_o,
    output logic [1:0]               mem_sram_resp_resp_o
);

    localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic                    req_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [7:0]              strb_q;
    logic [DATA_BUS-1:0]     wdata_q;
    resp_e                   resp_q;
    logic [DATA_BUS-1:0]     rdata_q;

    logic [DATA_BUS-1:0]     mem [WORDS];

    logic [DATA_ADDR_BUS-1:0] offset;
    logic                     in_range;
    logic                     misaligned;
    logic [7:0]               acc_strb;
    logic [DATA_BUS-1:0]      acc_wdata;
    resp_e                    acc_resp;
    logic [DEPTH_LOG2-1:0]    acc_idx;
    logic                     accept;
    logic                     enter_resp;
    logic                     cur_req;
    resp_e                    cur_resp;
    logic [DEPTH_LOG2-1:0]    rd_idx;
    logic [DATA_BUS-1:0]      wr_word;

    // BASE_ADDR is dword aligned, so offset[2:0] equals addr[2:0].
    assign offset   = mem_sram_resp_addr_i - BASE_ADDR;
    assign in_range = (mem_sram_resp_addr_i >= BASE_ADDR) && (offset[63:DEPTH_LOG2+3] == '0);
    assign acc_idx  = offset[DEPTH_LOG2+2:3];

    mem_sram_resp_lane u_lane (
        .size          (mem_sram_resp_size_i),
        .offset        (offset[2:0]),
        .wdata         (mem_sram_resp_data_write_i),
        .strobe        (acc_strb),
        .wdata_shifted (acc_wdata),
        .misaligned    (misaligned)
    );

    assign acc_resp = misaligned ? RESP_SLVERR : (!in_range ? RESP_DECERR : RESP_OKAY);
    assign accept   = (state_q == ST_IDLE) && mem_sram_resp_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_sram_resp_valid_i) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (!mem_sram_resp_valid_i) state_d = ST_IDLE;
                else if (cnt_q == 4'd1)     state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q   <= mem_sram_resp_req_i;
                idx_q   <= acc_idx;
                strb_q  <= acc_strb;
                wdata_q <= acc_wdata;
                resp_q  <= acc_resp;
                cnt_q   <= LAT;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // With LATENCY=0 the read happens on the accept edge, before the request is latched.
    assign cur_req    = (state_q == ST_IDLE) ? mem_sram_resp_req_i : req_q;
    assign cur_resp   = (state_q == ST_IDLE) ? acc_resp : resp_q;
    assign rd_idx     = (state_q == ST_IDLE) ? acc_idx : idx_q;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_comb begin
        wr_word = mem[idx_q];
        for (int b = 0; b < 8; b++) begin
            if (strb_q[b]) wr_word[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // NOTE: the array and read register carry no reset; outputs are gated by ready, which is reset.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            rdata_q <= (cur_req != REQ_WRITE && cur_resp == RESP_OKAY) ? mem[rd_idx] : '0;
        end
        if (!rst && state_q == ST_RESP && req_q == REQ_WRITE && resp_q == RESP_OKAY) begin
            mem[idx_q] <= wr_word;
        end
    end

    assign mem_sram_resp_ready_o     = (state_q == ST_RESP);
    assign mem_sram_resp_data_read_o = mem_sram_resp_ready_o ? rdata_q : '0;
    assign mem_sram_resp_resp_o      = mem_sram_resp_ready_o ? resp_q : RESP_OKAY;

endmodule

// File: tb/tb_mem_sram_resp.sv
// Scoreboard bench for mem_sram_resp: instance 0 uses LATENCY=2, instance 1
// uses LATENCY=0 for the back-to-back and read-after-write sequences.
module tb_mem_sram_resp;
    import mem_sram_resp_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic        W    = 1'b1;
    localparam logic        R    = 1'b0;

    typedef struct packed {
        logic        req;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [1:0]  resp;
        logic [63:0] data;
    } txn_t;

    typedef struct packed {
        logic [7:0]  lat;
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid [2];
    logic        req   [2];
    logic [63:0] addr  [2];
    logic [1:0]  size  [2];
    logic [63:0] wdata [2];
    logic        ready [2];
    logic [63:0] rdata [2];
    logic [1:0]  resp  [2];

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_sram_resp #(.BASE_ADDR(BASE), .DEPTH_LOG2(16), .LATENCY(2)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .mem_sram_resp_valid_i      (valid[0]),
        .mem_sram_resp_req_i        (req[0]),
        .mem_sram_resp_addr_i       (addr[0]),
        .mem_sram_resp_size_i       (size[0]),
        .mem_sram_resp_data_write_i (wdata[0]),
        .mem_sram_resp_ready_o      (ready[0]),
        .mem_sram_resp_data_read_o  (rdata[0]),
        .mem_sram_resp_resp_o       (resp[0])
    );

    mem_sram_resp #(.BASE_ADDR(BASE), .DEPTH_LOG2(16), .LATENCY(0)) dut_lat0 (
        .clk                        (clk),
        .rst                        (rst),
        .mem_sram_resp_valid_i      (valid[1]),
        .mem_sram_resp_req_i        (req[1]),
        .mem_sram_resp_addr_i       (addr[1]),
        .mem_sram_resp_size_i       (size[1]),
        .mem_sram_resp_data_write_i (wdata[1]),
        .mem_sram_resp_ready_o      (ready[1]),
        .mem_sram_resp_data_read_o  (rdata[1]),
        .mem_sram_resp_resp_o       (resp[1])
    );

    // Called at a negedge with the responder idle; returns at a negedge with it idle again.
    task automatic run_txn(input int sel, input txn_t t, output logic [7:0] lat,
                           output logic [1:0] rsp, output logic [63:0] dat);
        valid[sel] = 1'b1;
        req[sel]   = t.req;
        addr[sel]  = t.addr;
        size[sel]  = t.size;
        wdata[sel] = t.wdata;
        lat = 8'hFF;
        rsp = 2'b01;
        dat = '0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready[sel] === 1'b1) begin
                lat = 8'(n + 1);
                rsp = resp[sel];
                dat = rdata[sel];
                break;
            end
        end
        valid[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) valid[s] = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (ready[s] !== 1'b0 || rdata[s] !== 64'h0 || resp[s] !== 2'b00) begin
                miscompares++;
                $display("FAIL reset[%0d]: got ready=%b data=%h resp=%b, want ready=0 data=0 resp=00",
                         s, ready[s], rdata[s], resp[s]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dword_rw;
        txn_t tbl [4];
        exp_t e;
        logic [7:0] lat; logic [1:0] rsp; logic [63:0] dat;
        tbl = '{
            '{W, BASE + 64'h10, SIZE_D, 64'h1122_3344_5566_7788, RESP_OKAY, 64'h0},
            '{R, BASE + 64'h10, SIZE_D, 64'h0,                   RESP_OKAY, 64'h1122_3344_5566_7788},
            '{W, BASE + 64'h18, SIZE_D, 64'hA5A5_5A5A_0F0F_F0F0, RESP_OKAY, 64'h0},
            '{R, BASE + 64'h18, SIZE_D, 64'h0,                   RESP_OKAY, 64'hA5A5_5A5A_0F0F_F0F0}
        };
        foreach (tbl[i]) begin
            sb.push_back('{lat: 8'd3, resp: tbl[i].resp, data: tbl[i].data});
            run_txn(0, tbl[i], lat, rsp, dat);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat || rsp !== e.resp || dat !== e.data) begin
                miscompares++;
                $display("FAIL dword_rw[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                         i, lat, rsp, dat, e.lat, e.resp, e.data);
            end
        end
    endtask

    task automatic test_byte_write;
        txn_t tbl [7];
        exp_t e;
        logic [7:0] lat; logic [1:0] rsp; logic [63:0] dat;
        tbl = '{
            '{W, BASE + 64'h10, SIZE_D, 64'h0,                   RESP_OKAY, 64'h0},
            '{W, BASE + 64'h13, SIZE_B, 64'hFFFF_FFFF_FFFF_FFAB, RESP_OKAY, 64'h0},
            '{R, BASE + 64'h10, SIZE_D, 64'h0,                   RESP_OKAY, 64'h0000_0000_AB00_0000},
            '{W, BASE + 64'h16, SIZE_H, 64'hFFFF_FFFF_FFFF_1234, RESP_OKAY, 64'h0},
            '{R, BASE + 64'h11, SIZE_B, 64'h0,                   RESP_OKAY, 64'h1234_0000_AB00_0000},
            '{W, BASE + 64'h10, SIZE_W, 64'h9999_9999_CAFE_F00D, RESP_OKAY, 64'h0},
            '{R, BASE + 64'h10, SIZE_D, 64'h0,                   RESP_OKAY, 64'h1234_0000_CAFE_F00D}
        };
        foreach (tbl[i]) begin
            sb.push_back('{lat: 8'd3, resp: tbl[i].resp, data: tbl[i].data});
            run_txn(0, tbl[i], lat, rsp, dat);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat || rsp !== e.resp || dat !== e.data) begin
                miscompares++;
                $display("FAIL byte_write[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                         i, lat, rsp, dat, e.lat, e.resp, e.data);
            end
        end
    endtask

    task automatic test_misaligned;
        txn_t tbl [6];
        exp_t e;
        logic [7:0] lat; logic [1:0] rsp; logic [63:0] dat;
        tbl = '{
            '{W, BASE + 64'h0,          SIZE_D, 64'h0123_4567_89AB_CDEF, RESP_OKAY,   64'h0},
            '{W, BASE + 64'h6,          SIZE_W, 64'h0000_0000_DEAD_BEEF, RESP_SLVERR, 64'h0},
            '{W, BASE + 64'h1,          SIZE_H, 64'h0000_0000_0000_BEEF, RESP_SLVERR, 64'h0},
            '{R, BASE + 64'h4,          SIZE_D, 64'h0,                   RESP_SLVERR, 64'h0},
            '{W, 64'h0000_0000_7FFF_FFFF, SIZE_H, 64'h0000_0000_0000_5555, RESP_SLVERR, 64'h0},
            '{R, BASE + 64'h0,          SIZE_D, 64'h0,                   RESP_OKAY,   64'h0123_4567_89AB_CDEF}
        };
        foreach (tbl[i]) begin
            sb.push_back('{lat: 8'd3, resp: tbl[i].resp, data: tbl[i].data});
            run_txn(0, tbl[i], lat, rsp, dat);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat || rsp !== e.resp || dat !== e.data) begin
                miscompares++;
                $display("FAIL misaligned[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                         i, lat, rsp, dat, e.lat, e.resp, e.data);
            end
        end
    endtask

    task automatic test_out_of_range;
        txn_t tbl [7];
        exp_t e;
        logic [7:0] lat; logic [1:0] rsp; logic [63:0] dat;
        tbl = '{
            '{R, 64'h0000_0000_7FFF_FFF8, SIZE_D, 64'h0,                   RESP_DECERR, 64'h0},
            '{R, BASE + 64'h8_0000,       SIZE_D, 64'h0,                   RESP_DECERR, 64'h0},
            '{W, BASE + 64'h8_0000,       SIZE_D, 64'hBAD0_BAD0_BAD0_BAD0, RESP_DECERR, 64'h0},
            '{R, 64'hFFFF_FFFF_FFFF_FFF8, SIZE_D, 64'h0,                   RESP_DECERR, 64'h0},
            '{W, BASE + 64'h7_FFF8,       SIZE_D, 64'h55AA_66BB_77CC_88DD, RESP_OKAY,   64'h0},
            '{R, BASE + 64'h7_FFF8,       SIZE_D, 64'h0,                   RESP_OKAY,   64'h55AA_66BB_77CC_88DD},
            '{R, BASE + 64'h0,            SIZE_D, 64'h0,                   RESP_OKAY,   64'h0123_4567_89AB_CDEF}
        };
        foreach (tbl[i]) begin
            sb.push_back('{lat: 8'd3, resp: tbl[i].resp, data: tbl[i].data});
            run_txn(0, tbl[i], lat, rsp, dat);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat || rsp !== e.resp || dat !== e.data) begin
                miscompares++;
                $display("FAIL out_of_range[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                         i, lat, rsp, dat, e.lat, e.resp, e.data);
            end
        end
    endtask

    task automatic test_abort;
        txn_t wr, rd;
        exp_t e;
        logic seen;
        logic [7:0] lat; logic [1:0] rsp; logic [63:0] dat;
        wr = '{W, BASE + 64'h10, SIZE_D, 64'hFFFF_FFFF_FFFF_FFFF, RESP_OKAY, 64'h0};
        rd = '{R, BASE + 64'h10, SIZE_D, 64'h0, RESP_OKAY, 64'h1234_0000_CAFE_F00D};

        for (int k = 0; k < 3; k++) begin
            valid[0] = 1'b1; req[0] = wr.req; addr[0] = wr.addr; size[0] = wr.size; wdata[0] = wr.wdata;
            @(posedge clk);
            @(negedge clk);
            seen = ready[0];
            if (k == 0) begin
                // initiator withdraws during WAIT
                valid[0] = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (ready[0] === 1'b1) seen = 1'b1;
                end
                vectors++;
                if (seen !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_valid: got ready=1 after withdrawal, want no ready");
                end
            end else begin
                // k=1: reset on the WAIT->RESP edge; k=2: reset on the RESP edge
                for (int c = 0; c < 10 && ready[0] !== 1'b1 && k == 2; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                if (k == 1) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                vectors++;
                if (ready[0] !== 1'b0 || rdata[0] !== 64'h0 || resp[0] !== 2'b00) begin
                    miscompares++;
                    $display("FAIL abort_rst[%0d]: got ready=%b data=%h resp=%b, want ready=0 data=0 resp=00",
                             k, ready[0], rdata[0], resp[0]);
                end
                rst = 1'b0;
                valid[0] = 1'b0;
                @(negedge clk);
            end
            sb.push_back('{lat: 8'd3, resp: rd.resp, data: rd.data});
            run_txn(0, rd, lat, rsp, dat);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat || rsp !== e.resp || dat !== e.data) begin
                miscompares++;
                $display("FAIL abort_readback[%0d]: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                         k, lat, rsp, dat, e.lat, e.resp, e.data);
            end
        end
    endtask

    task automatic test_back_to_back;
        txn_t pre, tbl [3];
        exp_t e;
        logic [7:0] lat; logic [1:0] rsp; logic [63:0] dat;
        pre = '{W, BASE + 64'h28, SIZE_D, 64'h2222_2222_2222_2222, RESP_OKAY, 64'h0};
        sb.push_back('{lat: 8'd1, resp: pre.resp, data: pre.data});
        run_txn(1, pre, lat, rsp, dat);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || rsp !== e.resp || dat !== e.data) begin
            miscompares++;
            $display("FAIL b2b_prewrite: got lat=%0d resp=%b data=%h, want lat=%0d resp=%b data=%h",
                     lat, rsp, dat, e.lat, e.resp, e.data);
        end

        tbl = '{
            '{W, BASE + 64'h20, SIZE_D, 64'h3333_4444_5555_6666, RESP_OKAY, 64'h0},
            '{R, BASE + 64'h20, SIZE_D, 64'h0,                   RESP_OKAY, 64'h3333_4444_5555_6666},
            '{R, BASE + 64'h28, SIZE_D, 64'h0,                   RESP_OKAY, 64'h2222_2222_2222_2222}
        };
        foreach (tbl[i]) sb.push_back('{lat: 8'd1, resp: tbl[i].resp, data: tbl[i].data});

        valid[1] = 1'b1;
        req[1] = tbl[0].req; addr[1] = tbl[0].addr; size[1] = tbl[0].size; wdata[1] = tbl[0].wdata;
        foreach (tbl[i]) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (ready[1] !== 1'b1 || resp[1] !== e.resp || rdata[1] !== e.data) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got ready=%b resp=%b data=%h one cycle after accept, want ready=1 resp=%b data=%h",
                         i, ready[1], resp[1], rdata[1], e.resp, e.data);
            end
            if (i < 2) begin
                req[1] = tbl[i+1].req; addr[1] = tbl[i+1].addr; size[1] = tbl[i+1].size; wdata[1] = tbl[i+1].wdata;
            end else begin
                valid[1] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (ready[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_gap[%0d]: got ready=%b in cycle after response, want ready=0", i, ready[1]);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            valid[s] = 1'b0; req[s] = 1'b0; addr[s] = '0; size[s] = '0; wdata[s] = '0;
        end
        rst = 1'b1;
        test_reset();
        test_dword_rw();
        test_byte_write();
        test_misaligned();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
